// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path: opcodes, functs,
// FSM states, ALU operation codes and datapath mux selects.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B    = 2'b00;
    localparam logic [1:0] SRCB_4    = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_IMM2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_RTEX   = 4'd6,  S_RTWB  = 4'd7,
        S_BEQ    = 4'd8,  S_IMMEX  = 4'd9,  S_IMMWB  = 4'd10, S_JUMP  = 4'd11
    } state_t;

    // What the ALU decoder should do in the current state.
    typedef enum logic [2:0] {
        AC_ADD, AC_SUB, AC_FUNCT, AC_IMM, AC_IMMWB
    } alu_cls_t;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
            OP_ADDI, OP_ANDI, OP_ORI, OP_J: op_supported = 1'b1;
            default:                        op_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU-control / extender-mode decode for the multi-cycle control FSM.
module alu_decoder
    import ctrl_pkg::*;
(
    input  alu_cls_t     i_cls,
    input  logic [5:0]   i_opcode,
    input  logic [5:0]   i_funct,
    output logic [2:0]   o_alu_ctrl,
    output logic         o_ext_zero,
    output logic         o_bad_funct
);

    always_comb begin
        o_alu_ctrl  = ALU_ADD;
        o_ext_zero  = 1'b0;
        o_bad_funct = 1'b0;
        case (i_cls)
            AC_SUB: o_alu_ctrl = ALU_SUB;
            AC_FUNCT: begin
                case (i_funct)
                    FN_ADD:  o_alu_ctrl = ALU_ADD;
                    FN_SUB:  o_alu_ctrl = ALU_SUB;
                    FN_AND:  o_alu_ctrl = ALU_AND;
                    FN_OR:   o_alu_ctrl = ALU_OR;
                    FN_SLT:  o_alu_ctrl = ALU_SLT;
                    default: o_bad_funct = 1'b1;
                endcase
            end
            // Logical immediates zero-extend; the mode is held through writeback.
            AC_IMM, AC_IMMWB: begin
                o_ext_zero = (i_opcode == OP_ANDI) || (i_opcode == OP_ORI);
                if (i_cls == AC_IMM) begin
                    case (i_opcode)
                        OP_ANDI: o_alu_ctrl = ALU_AND;
                        OP_ORI:  o_alu_ctrl = ALU_OR;
                        default: o_alu_ctrl = ALU_ADD;
                    endcase
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore control FSM for the shared multi-cycle MIPS datapath; outputs decode the
// current state, with only ir_write/pc_en looking at mem_ready/zero.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int OPW = 6,
    parameter int STW = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPW-1:0]   opcode,
    input  logic [OPW-1:0]   funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [2:0]       alu_ctrl,
    output logic [1:0]       pc_src,
    output logic             ext_zero,
    output logic             illegal,
    output logic [STW-1:0]   state_o
);

    state_t   r_state;
    state_t   w_dec_state;
    alu_cls_t w_cls;
    logic     w_bad_funct;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            case (r_state)
                S_FETCH:  r_state <= mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (opcode)
                        OP_LW, OP_SW:              r_state <= S_MEMADR;
                        OP_RTYPE:                  r_state <= S_RTEX;
                        OP_BEQ:                    r_state <= S_BEQ;
                        OP_ADDI, OP_ANDI, OP_ORI:  r_state <= S_IMMEX;
                        OP_J:                      r_state <= S_JUMP;
                        default:                   r_state <= S_FETCH;
                    endcase
                end
                S_MEMADR: r_state <= (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  r_state <= mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWR:  r_state <= mem_ready ? S_FETCH : S_MEMWR;
                S_RTEX:   r_state <= S_RTWB;
                S_IMMEX:  r_state <= S_IMMWB;
                default:  r_state <= S_FETCH;
            endcase
        end
    end

    // During reset the outputs look like FETCH, so the datapath sees a clean first cycle.
    assign w_dec_state = rst ? S_FETCH : r_state;
    assign state_o     = STW'(r_state);

    always_comb begin
        case (w_dec_state)
            S_RTEX:  w_cls = AC_FUNCT;
            S_BEQ:   w_cls = AC_SUB;
            S_IMMEX: w_cls = AC_IMM;
            S_IMMWB: w_cls = AC_IMMWB;
            default: w_cls = AC_ADD;
        endcase
    end

    alu_decoder u_alu_dec (
        .i_cls       (w_cls),
        .i_opcode    (opcode),
        .i_funct     (funct),
        .o_alu_ctrl  (alu_ctrl),
        .o_ext_zero  (ext_zero),
        .o_bad_funct (w_bad_funct)
    );

    always_comb begin
        pc_en      = 1'b0;
        iord       = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_B;
        pc_src     = PC_ALU;
        illegal    = 1'b0;
        case (w_dec_state)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = SRCB_4;
                ir_write  = mem_ready;
                pc_en     = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = SRCB_IMM2;
                illegal   = !op_supported(opcode);
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_RTEX: begin
                alu_src_a = 1'b1;
                illegal   = w_bad_funct;
            end
            S_RTWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BEQ: begin
                alu_src_a = 1'b1;
                pc_src    = PC_ALUOUT;
                pc_en     = zero;
            end
            S_IMMEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_IMMWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_src = PC_JUMP;
                pc_en  = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            pc_en     = 1'b0;
            ir_write  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed plus randomized instruction streams for multicycle_ctrl, checked
// cycle by cycle against a per-instruction expected-cycle model.
module tb_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg;
    logic       reg_write, alu_src_a, ext_zero, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctrl;
    logic [3:0] state_o;

    always #5 clk = ~clk;

    multicycle_ctrl #(.OPW(6), .STW(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
        .ext_zero(ext_zero), .illegal(illegal), .state_o(state_o)
    );

    typedef struct packed {
        logic       pc_en, iord, mem_read, mem_write, ir_write;
        logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_src;
        logic       ext_zero, illegal;
    } obs_t;

    obs_t w_obs;
    assign w_obs = {pc_en, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                    reg_write, alu_src_a, alu_src_b, alu_ctrl, pc_src, ext_zero, illegal};

    int n_cmp = 0;
    int n_bad = 0;
    logic [5:0] cur_op = 6'd0;
    logic [5:0] cur_fn = 6'd0;

    logic [5:0] LEGAL_OPS [0:7] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100,
                                    6'b001000, 6'b001100, 6'b001101, 6'b000010};
    logic [5:0] LEGAL_FNS [0:4] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [2:0] FN_CTRL   [0:4] = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

    function automatic obs_t blank();
        obs_t o = '0;
        o.alu_ctrl = 3'b010;
        return o;
    endfunction

    function automatic bit is_legal(input logic [5:0] op);
        for (int i = 0; i < 8; i++) if (LEGAL_OPS[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    // Drive one cycle's inputs at the falling edge, then compare mid-cycle.
    task automatic step(input string tag, input obs_t e, input logic [3:0] st,
                        input bit chk_st, input logic mr, input logic z,
                        input logic r = 1'b0);
        @(negedge clk);
        rst = r; mem_ready = mr; zero = z; opcode = cur_op; funct = cur_fn;
        #1;
        n_cmp++;
        assert (w_obs === e) else begin
            n_bad++;
            $error("FAIL %s outputs got=%h want=%h (op=%b fn=%b)", tag, w_obs, e, cur_op, cur_fn);
        end
        if (chk_st) begin
            n_cmp++;
            assert (state_o === st) else begin
                n_bad++;
                $error("FAIL %s state got=%0d want=%0d (op=%b)", tag, state_o, st, cur_op);
            end
        end
    endtask

    function automatic int pick(input int s);
        return (s < 0) ? int'($urandom_range(0, 2)) : s;
    endfunction

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic do_fetch(input int fst);
        obs_t e = blank();
        e.mem_read = 1'b1; e.alu_src_b = 2'b01;
        repeat (pick(fst)) step("fetch_wait", e, 4'd0, 1'b1, 1'b0, rb());
        e.ir_write = 1'b1; e.pc_en = 1'b1;
        step("fetch", e, 4'd0, 1'b1, 1'b1, rb());
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z, input int fst, input int mst);
        obs_t e;
        int   k;
        logic [2:0] ctl;
        bit   bad;
        cur_op = op; cur_fn = fn;
        do_fetch(fst);
        e = blank(); e.alu_src_b = 2'b11; e.illegal = !is_legal(op);
        step("decode", e, 4'd1, 1'b1, rb(), rb());
        if (!is_legal(op)) return;
        if (op == 6'b100011 || op == 6'b101011) begin
            e = blank(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            step("memadr", e, 4'd2, 1'b1, rb(), rb());
            e = blank(); e.iord = 1'b1;
            if (op == 6'b100011) e.mem_read = 1'b1; else e.mem_write = 1'b1;
            k = pick(mst);
            repeat (k) step(op == 6'b100011 ? "memrd_wait" : "memwr_wait", e,
                            op == 6'b100011 ? 4'd3 : 4'd5, 1'b1, 1'b0, rb());
            step(op == 6'b100011 ? "memrd" : "memwr", e,
                 op == 6'b100011 ? 4'd3 : 4'd5, 1'b1, 1'b1, rb());
            if (op == 6'b100011) begin
                e = blank(); e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
                step("memwb", e, 4'd4, 1'b1, rb(), rb());
            end
        end else if (op == 6'b000000) begin
            ctl = 3'b010; bad = 1'b1;
            for (int i = 0; i < 5; i++) if (LEGAL_FNS[i] == fn) begin ctl = FN_CTRL[i]; bad = 1'b0; end
            e = blank(); e.alu_src_a = 1'b1; e.alu_ctrl = ctl; e.illegal = bad;
            step("rtex", e, 4'd6, 1'b1, rb(), rb());
            e = blank(); e.reg_write = 1'b1; e.reg_dst = 1'b1;
            step("rtwb", e, 4'd7, 1'b1, rb(), rb());
        end else if (op == 6'b000100) begin
            e = blank(); e.alu_src_a = 1'b1; e.alu_ctrl = 3'b110; e.pc_src = 2'b01; e.pc_en = z;
            step("beq", e, 4'd8, 1'b1, rb(), z);
        end else if (op == 6'b000010) begin
            e = blank(); e.pc_src = 2'b10; e.pc_en = 1'b1;
            step("jump", e, 4'd11, 1'b1, rb(), rb());
        end else begin
            e = blank(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
            e.alu_ctrl = (op == 6'b001100) ? 3'b000 : (op == 6'b001101) ? 3'b001 : 3'b010;
            e.ext_zero = (op != 6'b001000);
            step("immex", e, 4'd9, 1'b1, rb(), rb());
            e = blank(); e.reg_write = 1'b1; e.ext_zero = (op != 6'b001000);
            step("immwb", e, 4'd10, 1'b1, rb(), rb());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired: got no finish, want finish");
        $fatal(1, "timeout");
    end

    initial begin
        obs_t e_rst;
        obs_t e;
        logic [5:0] op, fn;
        e_rst = blank(); e_rst.mem_read = 1'b1; e_rst.alu_src_b = 2'b01;

        // Reset: FETCH decode with writes suppressed even though mem_ready=1.
        step("reset0", e_rst, 4'd0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("reset1", e_rst, 4'd0, 1'b1, 1'b1, 1'b1, 1'b1);

        run_instr(6'b100011, 6'b000000, 1'b0, 0, 0);   // lw, no stalls
        run_instr(6'b101011, 6'b000000, 1'b0, 0, 3);   // sw, 3 wait cycles
        run_instr(6'b000000, 6'b100010, 1'b0, 0, 0);   // sub
        run_instr(6'b000000, 6'b011111, 1'b0, 0, 0);   // bad funct
        run_instr(6'b000100, 6'b000000, 1'b1, 0, 0);   // beq taken
        run_instr(6'b000100, 6'b000000, 1'b0, 0, 0);   // beq not taken
        run_instr(6'b001101, 6'b000000, 1'b0, 0, 0);   // ori
        run_instr(6'b001000, 6'b000000, 1'b0, 0, 0);   // addi
        run_instr(6'b001100, 6'b000000, 1'b0, 1, 0);   // andi
        run_instr(6'b000010, 6'b000000, 1'b0, 0, 0);   // j
        run_instr(6'b111111, 6'b000000, 1'b0, 0, 0);   // unsupported opcode

        // Reset asserted while in MEMRD aborts the load.
        cur_op = 6'b100011; cur_fn = 6'b000000;
        do_fetch(0);
        e = blank(); e.alu_src_b = 2'b11;
        step("abort_decode", e, 4'd1, 1'b1, 1'b1, 1'b0);
        e = blank(); e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
        step("abort_memadr", e, 4'd2, 1'b1, 1'b1, 1'b0);
        step("abort_rst", e_rst, 4'd3, 1'b1, 1'b1, 1'b0, 1'b1);
        e = e_rst;
        step("after_rst", e, 4'd0, 1'b1, 1'b0, 1'b0);

        for (int n = 0; n < 40; n++) begin
            int idx;
            idx = int'($urandom_range(0, 8));
            op = (idx == 8) ? 6'($urandom) : LEGAL_OPS[idx];
            fn = ($urandom_range(0, 3) == 0) ? 6'($urandom) : LEGAL_FNS[$urandom_range(0, 4)];
            run_instr(op, fn, rb(), -1, -1);
        end
        do_fetch(0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
